// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between an instruction and a data port; define ARB_ROUND_ROBIN_EN for round-robin, otherwise data has fixed priority
module mem_port_arbiter #(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 4096,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rren,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);
  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d, port_q, port_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, d_rdata_q, rdata_v;
  logic              i_ack_q, d_ack_q, err_q, gnt, oor, issue, fin;
`ifdef ARB_ROUND_ROBIN_EN
  assign gnt = (i_req && d_req) ? ~owner_q : d_req;
`else
  assign gnt = d_req;
`endif
  assign oor       = 64'(addr_q) >= 64'(MEM_WORDS);
  assign issue     = state_q == ISSUE && !oor;
  assign fin       = state_q == WAIT && cnt_q == LAT_LAST;
  assign rdata_v   = (we_q || oor) ? '0 : mem_rdata;
  assign mem_en    = issue;
  assign mem_wren  = issue && we_q;
  assign mem_rren  = issue && !we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = state_q != IDLE;
  assign owner     = owner_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_err     = err_q && i_ack_q;
  assign d_err     = err_q && d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  // next state: grant and latch in IDLE, one strobe cycle, MEM_LAT wait cycles, one ack cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    port_d  = port_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: if (i_req || d_req) begin
        state_d = ISSUE;
        owner_d = gnt;
        port_d  = gnt;
        we_d    = gnt && d_we;
        addr_d  = gnt ? d_addr : i_addr;
        wdata_d = gnt ? d_wdata : '0;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        state_d = fin ? DONE : WAIT;
        cnt_d   = fin ? '0 : cnt_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // FSM and latched transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      port_q  <= port_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  // response registers: loaded on the last wait cycle so ack/err/rdata appear in DONE, rdata held until that port's next ack
  always_ff @(posedge clk) begin
    if (rst) begin
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q <= fin && !port_q;
      d_ack_q <= fin && port_q;
      err_q   <= fin && oor;
      if (fin && !port_q) i_rdata_q <= rdata_v;
      if (fin && port_q) d_rdata_q <= rdata_v;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-timeline model checked every cycle plus directed literal checks
module tb_mem_port_arbiter;
  localparam int L  = 1;
  localparam int MW = 4096;
`ifdef ARB_ROUND_ROBIN_EN
  localparam int EXP_ND = 2;
  localparam int EXP_NI = 2;
`else
  localparam int EXP_ND = 4;
  localparam int EXP_NI = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [29:0] i_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        i_ack, i_err, d_ack, d_err, mem_wren, mem_rren, mem_en, busy, owner;
  logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [29:0] mem_addr;
  logic        q_i_req = 1'b0;
  logic [29:0] q_i_addr = '0;
  logic        q_i_ack, q_i_err, q_d_ack, q_d_err, q_mem_wren, q_mem_rren, q_mem_en, q_busy, q_owner;
  logic [31:0] q_i_rdata, q_d_rdata, q_mem_wdata, q_mem_rdata;
  logic [29:0] q_mem_addr;

  mem_port_arbiter #(.ADDR_W(30), .DATA_W(32), .MEM_WORDS(MW), .MEM_LAT(L)) u1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rren(mem_rren),
    .mem_en(mem_en), .mem_rdata(mem_rdata), .busy(busy), .owner(owner));

  mem_port_arbiter #(.ADDR_W(30), .DATA_W(32), .MEM_WORDS(MW), .MEM_LAT(4)) u4 (
    .clk(clk), .rst(rst),
    .i_req(q_i_req), .i_addr(q_i_addr), .i_ack(q_i_ack), .i_rdata(q_i_rdata), .i_err(q_i_err),
    .d_req(1'b0), .d_we(1'b0), .d_addr(30'd0), .d_wdata(32'd0),
    .d_ack(q_d_ack), .d_rdata(q_d_rdata), .d_err(q_d_err),
    .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata), .mem_wren(q_mem_wren), .mem_rren(q_mem_rren),
    .mem_en(q_mem_en), .mem_rdata(q_mem_rdata), .busy(q_busy), .owner(q_owner));

  function automatic logic [31:0] init_val(input int k);
    return k == 2112 ? 32'h11 : k == 0 ? 32'h20082000 : 32'(k) * 32'h00010001;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // memory behind u1: latency 1, unwritten words hold init_val
  logic [31:0] mem [MW];
  bit   [MW-1:0] wv;
  always @(posedge clk) begin
    if (mem_wren) begin
      mem[mem_addr[11:0]] <= mem_wdata;
      wv[mem_addr[11:0]]  <= 1'b1;
    end
    if (mem_rren) mem_rdata <= wv[mem_addr[11:0]] ? mem[mem_addr[11:0]] : init_val(int'(mem_addr[11:0]));
  end

  // read-only memory behind u4: data appears 4 edges after the strobe edge
  int pend4 = 0;
  logic [11:0] ra4 = '0;
  always @(posedge clk) begin
    if (q_mem_rren) begin
      pend4 <= 3;
      ra4   <= q_mem_addr[11:0];
    end else if (pend4 == 1) begin
      q_mem_rdata <= init_val(int'(ra4));
      pend4       <= 0;
    end else if (pend4 > 1) pend4 <= pend4 - 1;
  end

  // model: a granted transaction at cycle t strobes at t+1, acks at t+L+2, frees the arbiter at t+L+3
  initial begin
    logic [31:0] ref_mem [MW];
    logic        active, owner_m, m_port, m_we, m_oor, idle, gp;
    logic        ex_ia, ex_da, ex_ie, ex_de, ex_en, ex_wr, ex_rd;
    logic [29:0] m_addr;
    logic [31:0] m_wdata, ird, drd, r;
    int t, k;
    for (int a = 0; a < MW; a++) ref_mem[a] = init_val(a);
    active = 0; owner_m = 0; m_port = 0; m_we = 0; m_oor = 0; m_addr = '0; m_wdata = '0;
    ird = '0; drd = '0; t = 0;
    forever begin
      @(negedge clk);
      k = cyc - t;
      idle = !active;
      {ex_ia, ex_da, ex_ie, ex_de, ex_en, ex_wr, ex_rd} = '0;
      if (active && k == 1 && !m_oor) begin
        ex_en = 1; ex_wr = m_we; ex_rd = !m_we;
        if (m_we) ref_mem[m_addr[11:0]] = m_wdata;
      end
      if (active && k == L + 2) begin
        r = (m_we || m_oor) ? 32'd0 : ref_mem[m_addr[11:0]];
        if (m_port) begin ex_da = 1; ex_de = m_oor; drd = r; end
        else begin ex_ia = 1; ex_ie = m_oor; ird = r; end
      end
      if (chk_en) begin
        chk("busy", busy, active);
        chk("owner", owner, owner_m);
        chk("i_ack", i_ack, ex_ia);
        chk("d_ack", d_ack, ex_da);
        chk("i_err", i_err, ex_ie);
        chk("d_err", d_err, ex_de);
        chk("i_rdata", i_rdata, ird);
        chk("d_rdata", d_rdata, drd);
        chk("mem_en", mem_en, ex_en);
        chk("mem_wren", mem_wren, ex_wr);
        chk("mem_rren", mem_rren, ex_rd);
        if (active && k <= L + 1) chk("mem_addr", mem_addr, m_addr);
        if (active && k <= L + 1 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (rst) begin
        active = 0; owner_m = 0; ird = '0; drd = '0;
      end else if (idle && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
        gp = (i_req && d_req) ? !owner_m : d_req;
`else
        gp = d_req;
`endif
        owner_m = gp; m_port = gp; m_we = gp && d_we;
        m_addr = gp ? d_addr : i_addr;
        m_wdata = gp ? d_wdata : 32'd0;
        m_oor = m_addr >= 30'(MW);
        t = cyc; active = 1;
      end else if (active && k == L + 2) active = 0;
    end
  end

  task automatic xfer(input logic p, input logic we, input logic [29:0] a, input logic [31:0] wd,
                      output int lat, output int ac, output logic [31:0] rd, output logic er);
    int c0;
    c0 = cyc; lat = -1; ac = -1; rd = 32'hx; er = 1'bx;
    if (p) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
    else begin i_req = 1; i_addr = a; end
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (p ? d_ack : i_ack) begin
        ac = cyc; lat = cyc - c0;
        rd = p ? d_rdata : i_rdata;
        er = p ? d_err : i_err;
        break;
      end
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0; d_we = 0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int lat, a1, a2, nd, ni, first;
    logic [31:0] rd;
    logic er;
    repeat (3) @(posedge clk);
    #1;
    rst = 0; chk_en = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    chk("rst_memaddr", mem_addr, 0);
    chk("rst_owner", owner, 0);
    @(posedge clk); #1;
    i_req = 1; i_addr = 30'd5; d_req = 1; d_we = 0; d_addr = 30'd7;
    nd = 0; ni = 0; first = -1;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (first < 0 && (d_ack || i_ack)) first = d_ack ? 1 : 0;
      nd += int'(d_ack); ni += int'(i_ack);
    end
    @(posedge clk); #1;
    i_req = 0; d_req = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("both_nd", nd, EXP_ND);
    chk("both_ni", ni, EXP_NI);
    chk("both_first_d", first, 1);
    xfer(0, 0, 30'd2112, 0, lat, a1, rd, er);
    chk("i2112_lat", lat, 3);
    chk("i2112_data", rd, 32'h11);
    chk("i2112_err", er, 0);
    xfer(1, 1, 30'd2048, 32'hDEADBEEF, lat, a1, rd, er);
    chk("wr_lat", lat, 3);
    xfer(1, 0, 30'd2048, 0, lat, a2, rd, er);
    chk("rd_gap", a2 - a1, 6);
    chk("rd_data", rd, 32'hDEADBEEF);
    d_req = 1; d_we = 0; d_addr = 30'd2112;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; d_req = 0;
    @(negedge clk);
    chk("wait_busy", busy, 1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_noack", {i_ack, d_ack}, 0);
    chk("rst_idle", busy, 0);
    chk("rst_drdata", d_rdata, 0);
    chk("rst_irdata", i_rdata, 0);
    @(posedge clk); #1;
    xfer(1, 0, 30'd2112, 0, lat, a1, rd, er);
    chk("after_rst_lat", lat, 3);
    chk("after_rst_data", rd, 32'h11);
    xfer(1, 0, 30'd4096, 0, lat, a1, rd, er);
    chk("oor_lat", lat, 3);
    chk("oor_err", er, 1);
    chk("oor_data", rd, 0);
    q_i_req = 1; q_i_addr = 30'd0;
    a1 = cyc; lat = -1;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (q_i_ack) begin
        lat = cyc - a1;
        chk("lat4_data", q_i_rdata, 32'h20082000);
        chk("lat4_err", {q_i_err, q_d_ack, q_d_err}, 0);
        chk("lat4_busy", {q_busy, q_owner, q_mem_en, q_mem_wren}, 4'b1000);
        chk("lat4_drdata", q_d_rdata, 0);
        break;
      end
    end
    chk("lat4_lat", lat, 6);
    @(posedge clk); #1;
    q_i_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
